// File: rtl/walmult_dot_accum.sv
// walmult_dot_accum: saturating dot-product accumulator that sits behind the
// 8x8 Wallace-tree multiplier. One unsigned product term is absorbed per
// accepted handshake; after N_TERMS terms (or an early in_last) the sum,
// term count and saturation flag are latched and held on the output
// handshake until downstream takes them.
module walmult_dot_accum #(
    parameter int PROD_W  = 16,
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 19,
    parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              flush,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  term_cnt,
    output logic              overflow,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;
    logic               in_ready_r;
    logic [ACC_W-1:0]   acc_out_r;
    logic [CNT_W-1:0]   term_cnt_r;
    logic               overflow_r;
    logic               out_valid_r;

    logic [ACC_W-1:0]   next_acc_s;
    logic               next_ovf_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               term_end_s;
    logic [ACC_W:0]     sum_s;

    // One guard bit above the accumulator catches the carry that signals
    // the sum no longer fits and must be clamped.
    function automatic logic [ACC_W:0] wide_sum(input logic [ACC_W-1:0]  a,
                                                input logic [PROD_W-1:0] p);
        return {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
    endfunction

    // Next accumulator value, sticky saturation and end-of-vector detection
    // for the term currently presented.
    always_comb begin
        sum_s      = wide_sum(acc_r, prod_in);
        next_acc_s = sum_s[ACC_W-1:0];
        next_ovf_s = ovf_r;
        cnt_inc_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        term_end_s = 1'b0;
        if (sum_s[ACC_W]) begin
            next_acc_s = {ACC_W{1'b1}};
            next_ovf_s = 1'b1;
        end else begin
            next_acc_s = sum_s[ACC_W-1:0];
        end
        if ((cnt_inc_s == CNT_W'(N_TERMS)) || in_last) begin
            term_end_s = 1'b1;
        end else begin
            term_end_s = 1'b0;
        end
    end

    // Two-state handshake controller with all outputs registered; reset wins
    // over everything, flush only acts while a vector is being gathered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            acc_out_r   <= {ACC_W{1'b0}};
            term_cnt_r  <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (flush) begin
                        acc_r <= {ACC_W{1'b0}};
                        cnt_r <= {CNT_W{1'b0}};
                        ovf_r <= 1'b0;
                    end else if (in_valid) begin
                        if (term_end_s) begin
                            acc_out_r   <= next_acc_s;
                            term_cnt_r  <= cnt_inc_s;
                            overflow_r  <= next_ovf_s;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                            state_r     <= ST_DONE;
                        end else begin
                            acc_r <= next_acc_s;
                            cnt_r <= cnt_inc_s;
                            ovf_r <= next_ovf_s;
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        acc_r       <= {ACC_W{1'b0}};
                        cnt_r       <= {CNT_W{1'b0}};
                        ovf_r       <= 1'b0;
                        state_r     <= ST_ACCUM;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_ACCUM;
                    acc_r       <= {ACC_W{1'b0}};
                    cnt_r       <= {CNT_W{1'b0}};
                    ovf_r       <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign acc_out   = acc_out_r;
    assign term_cnt  = term_cnt_r;
    assign overflow  = overflow_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_walmult_dot_accum.sv
// Bench for walmult_dot_accum: instance 0 uses default parameters, instance 1
// uses ACC_W=17 / N_TERMS=4 so saturation can be reached. A behavioural
// model predicts every output each cycle; directed tests add literal checks.
module tb_walmult_dot_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prod [2];
    logic        vld  [2];
    logic        lst  [2];
    logic        fl   [2];
    logic        ordy [2];

    logic        rdy0, rdy1, ov0, ov1, outv0, outv1;
    logic [18:0] acc0;
    logic [16:0] acc1;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    walmult_dot_accum dut0 (
        .clk(clk), .rst(rst), .prod_in(prod[0]), .in_valid(vld[0]),
        .in_last(lst[0]), .in_ready(rdy0), .flush(fl[0]), .acc_out(acc0),
        .term_cnt(cnt0), .overflow(ov0), .out_valid(outv0), .out_ready(ordy[0])
    );

    walmult_dot_accum #(.PROD_W(16), .N_TERMS(4), .ACC_W(17)) dut1 (
        .clk(clk), .rst(rst), .prod_in(prod[1]), .in_valid(vld[1]),
        .in_last(lst[1]), .in_ready(rdy1), .flush(fl[1]), .acc_out(acc1),
        .term_cnt(cnt1), .overflow(ov1), .out_valid(outv1), .out_ready(ordy[1])
    );

    function automatic int acc_max(input int i);
        return (i == 0) ? ((1 << 19) - 1) : ((1 << 17) - 1);
    endfunction

    function automatic int n_terms(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    function automatic int d_acc(input int i);
        return (i == 0) ? int'(acc0) : int'(acc1);
    endfunction
    function automatic int d_cnt(input int i);
        return (i == 0) ? int'(cnt0) : int'(cnt1);
    endfunction
    function automatic int d_ovf(input int i);
        return (i == 0) ? int'(ov0) : int'(ov1);
    endfunction
    function automatic int d_vld(input int i);
        return (i == 0) ? int'(outv0) : int'(outv1);
    endfunction
    function automatic int d_rdy(input int i);
        return (i == 0) ? int'(rdy0) : int'(rdy1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: running integer sum of the vector being gathered,
    // clamped to the accumulator maximum, and a pending published result.
    int m_sum  [2];
    int m_n    [2];
    bit m_sat  [2];
    bit m_pend [2];
    int e_acc  [2];
    int e_cnt  [2];
    bit e_ovf  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_sum[i] = 0; m_n[i] = 0; m_sat[i] = 1'b0; m_pend[i] = 1'b0;
                e_acc[i] = 0; e_cnt[i] = 0; e_ovf[i] = 1'b0;
            end else if (m_pend[i]) begin
                if (ordy[i]) begin
                    m_pend[i] = 1'b0;
                    m_sum[i] = 0; m_n[i] = 0; m_sat[i] = 1'b0;
                end
            end else if (fl[i]) begin
                m_sum[i] = 0; m_n[i] = 0; m_sat[i] = 1'b0;
            end else if (vld[i]) begin
                int s;
                s = m_sum[i] + int'(prod[i]);
                if (s > acc_max(i)) begin
                    s = acc_max(i);
                    m_sat[i] = 1'b1;
                end
                m_sum[i] = s;
                m_n[i]   = m_n[i] + 1;
                if (m_n[i] == n_terms(i) || lst[i]) begin
                    e_acc[i] = m_sum[i]; e_cnt[i] = m_n[i]; e_ovf[i] = m_sat[i];
                    m_pend[i] = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d_out_valid", i), d_vld(i), int'(m_pend[i]));
                chk($sformatf("m%0d_in_ready", i), d_rdy(i), int'(!m_pend[i]));
                chk($sformatf("m%0d_acc_out", i), d_acc(i), e_acc[i]);
                chk($sformatf("m%0d_term_cnt", i), d_cnt(i), e_cnt[i]);
                chk($sformatf("m%0d_overflow", i), d_ovf(i), int'(e_ovf[i]));
            end
        end
    end

    // Present one term and hold it until the instance accepts it.
    task automatic send(input int i, input int val, input bit last);
        int k;
        k = 0;
        prod[i] = 16'(val); vld[i] = 1'b1; lst[i] = last;
        while (d_rdy(i) == 0 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 50) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        vld[i] = 1'b0; lst[i] = 1'b0;
    endtask

    // Literal checks right after the terminating accept edge.
    task automatic expect_result(input string tag, input int i, input int a,
                                 input int c, input int o);
        chk({tag, "_valid"}, d_vld(i), 1);
        chk({tag, "_acc"}, d_acc(i), a);
        chk({tag, "_cnt"}, d_cnt(i), c);
        chk({tag, "_ovf"}, d_ovf(i), o);
        chk({tag, "_rdy_low"}, d_rdy(i), 0);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            prod[i] = 16'd0; vld[i] = 1'b0; lst[i] = 1'b0;
            fl[i] = 1'b0; ordy[i] = 1'b1;
        end
        tick;
        checking = 1'b1;
        tick;
        rst = 1'b0;
        chk("reset_acc", d_acc(0), 0);
        chk("reset_valid", d_vld(0), 0);
        chk("reset_ready", d_rdy(0), 1);
        tick;

        // Four-term vector ended by in_last, out_ready held high.
        send(0, 21, 1'b0); send(0, 441, 1'b0); send(0, 7920, 1'b0); send(0, 9180, 1'b1);
        expect_result("dot4", 0, 17562, 4, 0);
        tick;
        chk("dot4_one_cycle", d_vld(0), 0);
        chk("dot4_ready_back", d_rdy(0), 1);

        // Eight maximum products back to back: terminates on count.
        for (int k = 0; k < 8; k++) send(0, 65025, 1'b0);
        expect_result("full8", 0, 520200, 8, 0);
        tick;

        // Saturating instance, then a single-term vector clears the flag.
        send(1, 65025, 1'b0); send(1, 65025, 1'b0); send(1, 65025, 1'b0); send(1, 1, 1'b0);
        expect_result("sat", 1, 131071, 4, 1);
        tick;
        send(1, 5, 1'b1);
        expect_result("sat_clear", 1, 5, 1, 0);
        tick;

        // Backpressure: result held, a waiting 100 is not absorbed.
        ordy[0] = 1'b0;
        send(0, 10, 1'b0); send(0, 20, 1'b1);
        prod[0] = 16'd100; vld[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("bp_hold_acc", d_acc(0), 30);
            chk("bp_hold_valid", d_vld(0), 1);
            chk("bp_rdy_low", d_rdy(0), 0);
        end
        ordy[0] = 1'b1;
        tick;
        vld[0] = 1'b0;
        chk("bp_released", d_vld(0), 0);
        chk("bp_last_acc_kept", d_acc(0), 30);
        send(0, 4, 1'b1);
        expect_result("bp_next", 0, 4, 1, 0);
        tick;

        // Flush discards partial sum and the term presented with it.
        send(0, 300, 1'b0); send(0, 400, 1'b0);
        fl[0] = 1'b1; prod[0] = 16'd500; vld[0] = 1'b1;
        tick;
        fl[0] = 1'b0; vld[0] = 1'b0;
        chk("flush_no_out", d_vld(0), 0);
        send(0, 7, 1'b1);
        expect_result("flush", 0, 7, 1, 0);
        tick;

        // Reset in the middle of a vector.
        send(0, 11, 1'b0); send(0, 12, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_valid", d_vld(0), 0);
        chk("rst_mid_acc", d_acc(0), 0);
        chk("rst_mid_ready", d_rdy(0), 1);
        send(0, 9, 1'b1);
        expect_result("rst_mid_next", 0, 9, 1, 0);
        tick;
        tick;

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
